iir_tap_sequencer: RTL and testbench

IIR_TAP_SEQUENCER -- requirements
Module: iir_tap_sequencer

---
 rtl/iir_tap_sequencer.sv | 172 +++++++++++++++++
 tb/tb_iir_tap_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_tap_sequencer.sv
// Operand sequencer for a direct-form IIR: streams (coef, history) pairs to a multiplier.
// Define IIR_FEEDBACK_EN to build the feedback (a/y) path; otherwise FIR-only.
module iir_tap_sequencer #(
    parameter int WIDTH     = 32,
    parameter int WIDTH_exp = 8,
    parameter int NB        = 3,
    parameter int NA        = 2,
    localparam int AW       = (NB + NA > 1) ? $clog2(NB + NA) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             coef_we,
    input  logic [AW-1:0]    coef_addr,
    input  logic [WIDTH-1:0] coef_data,
    output logic             coef_ack,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x_data,
    output logic             x_ready,
    input  logic             y_valid,
    input  logic [WIDTH-1:0] y_data,
    output logic [WIDTH-1:0] OP1,
    output logic [WIDTH-1:0] OP2,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             op_fb,
    output logic             op_last,
    output logic             exce_out,
    output logic             busy
);
    localparam int MAXT  = (NB > NA) ? NB : NA;
    localparam int IW    = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam int DEPTH = 1 << IW;

    // IDLE: await sample | FF: b taps | FB: a taps | WAIT_Y: await accumulator result
    typedef enum logic [1:0] {IDLE, FF, FB, WAIT_Y} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] b_q [DEPTH];
    logic [WIDTH-1:0] x_q [DEPTH];
    logic             coef_ack_q;
    logic             x_accept;
    logic             coef_hit;
    logic             pair_acc;

    assign x_ready  = (state_q == IDLE);
    assign x_accept = x_ready && x_valid;
    assign pair_acc = op_valid && op_ready;
    assign busy     = (state_q != IDLE);
    assign coef_ack = coef_ack_q;

`ifdef IIR_FEEDBACK_EN
    logic [WIDTH-1:0] a_q [DEPTH];
    logic [WIDTH-1:0] y_q [DEPTH];
    assign coef_hit = x_ready && coef_we && (int'(coef_addr) < NB + NA);
`else
    logic unused_y;
    assign unused_y = ^{y_valid, y_data};
    assign coef_hit = x_ready && coef_we && (int'(coef_addr) < NB);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (x_accept) begin
                    state_d = FF;
                    idx_d   = '0;
                end
            end
            FF: begin
                if (pair_acc) begin
                    if (idx_q == IW'(NB - 1)) begin
                        idx_d = '0;
`ifdef IIR_FEEDBACK_EN
                        state_d = FB;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef IIR_FEEDBACK_EN
            FB: begin
                if (pair_acc) begin
                    if (idx_q == IW'(NA - 1)) begin
                        idx_d   = '0;
                        state_d = WAIT_Y;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WAIT_Y: begin
                if (y_valid) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_valid = 1'b0;
        OP1      = '0;
        OP2      = '0;
        op_fb    = 1'b0;
        op_last  = 1'b0;
        case (state_q)
            FF: begin
                op_valid = 1'b1;
                OP1      = b_q[idx_q];
                OP2      = x_q[idx_q];
`ifndef IIR_FEEDBACK_EN
                op_last  = (idx_q == IW'(NB - 1));
`endif
            end
`ifdef IIR_FEEDBACK_EN
            FB: begin
                op_valid = 1'b1;
                OP1      = a_q[idx_q];
                OP2      = y_q[idx_q];
                op_fb    = 1'b1;
                op_last  = (idx_q == IW'(NA - 1));
            end
`endif
            default: ;
        endcase
    end

    // Infinity/NaN on either operand is flagged to the multiplier
    assign exce_out = op_valid && ((&OP1[WIDTH-2 -: WIDTH_exp]) || (&OP2[WIDTH-2 -: WIDTH_exp]));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            coef_ack_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                b_q[k] <= '0;
                x_q[k] <= '0;
`ifdef IIR_FEEDBACK_EN
                a_q[k] <= '0;
                y_q[k] <= '0;
`endif
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            coef_ack_q <= coef_hit;
            for (int k = 0; k < NB; k++) begin
                if (coef_hit && int'(coef_addr) == k) b_q[k] <= coef_data;
            end
`ifdef IIR_FEEDBACK_EN
            for (int k = 0; k < NA; k++) begin
                if (coef_hit && int'(coef_addr) == NB + k) a_q[k] <= coef_data;
            end
            if (state_q == WAIT_Y && y_valid) begin
                y_q[0] <= y_data;
                for (int k = 1; k < NA; k++) y_q[k] <= y_q[k-1];
            end
`endif
            if (x_accept) begin
                x_q[0] <= x_data;
                for (int k = 1; k < NB; k++) x_q[k] <= x_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_iir_tap_sequencer.sv
// Self-checking bench for iir_tap_sequencer; honours IIR_FEEDBACK_EN like the design.
module tb_iir_tap_sequencer;
    localparam int NB = 3;
    localparam int NA = 2;
`ifdef IIR_FEEDBACK_EN
    localparam bit FBEN = 1'b1;
`else
    localparam bit FBEN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [31:0] coef_data = '0;
    logic        coef_ack;
    logic        x_valid = 1'b0;
    logic [31:0] x_data = '0;
    logic        x_ready;
    logic        y_valid = 1'b0;
    logic [31:0] y_data = '0;
    logic [31:0] OP1, OP2;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic        op_fb, op_last, exce_out, busy;

    iir_tap_sequencer #(.WIDTH(32), .WIDTH_exp(8), .NB(NB), .NA(NA)) dut (
        .CLK(CLK), .RST(RST), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_ack(coef_ack), .x_valid(x_valid),
        .x_data(x_data), .x_ready(x_ready), .y_valid(y_valid), .y_data(y_data),
        .OP1(OP1), .OP2(OP2), .op_valid(op_valid), .op_ready(op_ready),
        .op_fb(op_fb), .op_last(op_last), .exce_out(exce_out), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        fb;
        logic        last;
        logic        exce;
    } pair_t;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic        ack;
    } cvec_t;

    pair_t       q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          acc_cnt = 0;
    logic [31:0] mb [NB];
    logic [31:0] ma [NA];
    logic [31:0] mx [NB];
    logic [31:0] my [NA];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic inf_exp(input logic [31:0] v);
        return &v[30:23];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NB; k++) begin mb[k] = '0; mx[k] = '0; end
        for (int k = 0; k < NA; k++) begin ma[k] = '0; my[k] = '0; end
    endtask

    task automatic model_write(input logic [2:0] addr, input logic [31:0] data);
        if (int'(addr) < NB) mb[int'(addr)] = data;
        else ma[int'(addr) - NB] = data;
    endtask

    task automatic push_sample(input logic [31:0] x);
        pair_t p;
        for (int k = NB - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = x;
        for (int i = 0; i < NB; i++) begin
            p.op1 = mb[i]; p.op2 = mx[i]; p.fb = 1'b0;
            p.last = !FBEN && (i == NB - 1);
            p.exce = inf_exp(mb[i]) || inf_exp(mx[i]);
            q.push_back(p);
        end
        if (FBEN) begin
            for (int j = 0; j < NA; j++) begin
                p.op1 = ma[j]; p.op2 = my[j]; p.fb = 1'b1;
                p.last = (j == NA - 1);
                p.exce = inf_exp(ma[j]) || inf_exp(my[j]);
                q.push_back(p);
            end
        end
    endtask

    // Every presented pair is compared to the scoreboard head, including stalled cycles
    always @(negedge CLK) begin
        if (!RST && op_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_op_valid", {31'b0, op_valid}, 32'h0);
            end else begin
                chk($sformatf("OP1[%0d]", acc_cnt), OP1, q[0].op1);
                chk($sformatf("OP2[%0d]", acc_cnt), OP2, q[0].op2);
                chk($sformatf("op_fb[%0d]", acc_cnt), {31'b0, op_fb}, {31'b0, q[0].fb});
                chk($sformatf("op_last[%0d]", acc_cnt), {31'b0, op_last}, {31'b0, q[0].last});
                chk($sformatf("exce_out[%0d]", acc_cnt), {31'b0, exce_out}, {31'b0, q[0].exce});
                if (op_ready) begin
                    void'(q.pop_front());
                    acc_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_coef(input logic [2:0] addr, input logic [31:0] data, input logic exp_ack);
        coef_we = 1'b1; coef_addr = addr; coef_data = data;
        if (exp_ack) model_write(addr, data);
        tick();
        coef_we = 1'b0;
        chk($sformatf("coef_ack@%0d", addr), {31'b0, coef_ack}, {31'b0, exp_ack});
    endtask

    task automatic start_sample(input logic [31:0] x);
        x_valid = 1'b1; x_data = x;
        push_sample(x);
        tick();
        x_valid = 1'b0;
        chk("first_valid_latency", {31'b0, op_valid}, 32'h1);
        chk("x_ready_busy", {31'b0, x_ready}, 32'h0);
    endtask

    task automatic drain(input int stall_pair, input int stall_len);
        int base, stalled, cyc;
        base = acc_cnt; stalled = 0; cyc = 0;
        while (q.size() != 0 && cyc < 100) begin
            if (acc_cnt - base == stall_pair && stalled < stall_len) begin
                op_ready = 1'b0; stalled++;
            end else begin
                op_ready = 1'b1;
            end
            tick();
            cyc++;
        end
        op_ready = 1'b1;
        if (q.size() != 0) begin
            chk("drain_timeout_pending", q.size(), 32'h0);
            q.delete();
        end
`ifdef IIR_FEEDBACK_EN
        chk("wait_y_busy", {31'b0, busy}, 32'h1);
        chk("wait_y_no_valid", {31'b0, op_valid}, 32'h0);
`else
        chk("done_idle_busy", {31'b0, busy}, 32'h0);
`endif
    endtask

`ifdef IIR_FEEDBACK_EN
    task automatic give_y(input logic [31:0] y);
        y_valid = 1'b1; y_data = y;
        for (int k = NA - 1; k > 0; k--) my[k] = my[k-1];
        my[0] = y;
        tick();
        y_valid = 1'b0;
        chk("y_return_idle", {31'b0, busy}, 32'h0);
    endtask
`endif

    cvec_t cv [8];

    initial begin
        cv[0] = '{3'd0, 32'h3F800000, 1'b1};
        cv[1] = '{3'd1, 32'h40000000, 1'b1};
        cv[2] = '{3'd2, 32'h40400000, 1'b1};
        cv[3] = '{3'd3, 32'h3F000000, FBEN};
        cv[4] = '{3'd4, 32'h3E800000, FBEN};
        cv[5] = '{3'd5, 32'hDEADBEEF, 1'b0};
        cv[6] = '{3'd7, 32'h12345678, 1'b0};
        cv[7] = '{3'd6, 32'hCAFEF00D, 1'b0};
        model_clear();

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_op_valid", {31'b0, op_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_coef_ack", {31'b0, coef_ack}, 32'h0);
        chk("rst_exce", {31'b0, exce_out}, 32'h0);
        chk("rst_OP1", OP1, 32'h0);
        chk("rst_OP2", OP2, 32'h0);
        chk("rst_op_last", {31'b0, op_last}, 32'h0);
        chk("rst_op_fb", {31'b0, op_fb}, 32'h0);
        RST = 1'b0;
        chk("rst_x_ready", {31'b0, x_ready}, 32'h1);

        for (int i = 0; i < 8; i++) begin
            write_coef(cv[i].addr, cv[i].data, cv[i].ack);
            tick();
            chk("coef_ack_one_cycle", {31'b0, coef_ack}, 32'h0);
        end

        start_sample(32'h3F800000);
        drain(-1, 0);
`ifdef IIR_FEEDBACK_EN
        give_y(32'h40A00000);
`endif

        start_sample(32'h40000000);
        drain(1, 4);
`ifdef IIR_FEEDBACK_EN
        give_y(32'h40C00000);
`endif

        write_coef(3'd1, 32'h7F800000, 1'b1);
        start_sample(32'h40400000);
        drain(-1, 0);
`ifdef IIR_FEEDBACK_EN
        give_y(32'h3F800000);
`endif
        write_coef(3'd1, 32'h40000000, 1'b1);

        // Sample and coefficient traffic while busy must be ignored
        start_sample(32'h40800000);
        op_ready = 1'b0;
        x_valid = 1'b1; x_data = 32'hDEADBEEF;
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 32'h12345678;
        y_valid = 1'b1; y_data = 32'hCAFEF00D;
        chk("x_ready_in_ff", {31'b0, x_ready}, 32'h0);
        tick();
        chk("no_ack_when_busy", {31'b0, coef_ack}, 32'h0);
        x_valid = 1'b0; coef_we = 1'b0; y_valid = 1'b0;
        tick();
        chk("no_ack_when_busy2", {31'b0, coef_ack}, 32'h0);
        drain(-1, 0);
`ifdef IIR_FEEDBACK_EN
        give_y(32'h41000000);
`endif

        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 32'h40800000;
        x_valid = 1'b1; x_data = 32'h3F800000;
        model_write(3'd0, 32'h40800000);
        push_sample(32'h3F800000);
        tick();
        coef_we = 1'b0; x_valid = 1'b0;
        chk("coef_ack_coincident", {31'b0, coef_ack}, 32'h1);
        chk("valid_coincident", {31'b0, op_valid}, 32'h1);
        drain(-1, 0);
`ifdef IIR_FEEDBACK_EN
        give_y(32'h41100000);
`endif

        // Reset in the middle of a sample abandons it
        start_sample(32'h40A00000);
        op_ready = 1'b1;
`ifdef IIR_FEEDBACK_EN
        repeat (NB) tick();
`else
        tick();
`endif
        op_ready = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        q.delete();
        model_clear();
        chk("abort_op_valid", {31'b0, op_valid}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_x_ready", {31'b0, x_ready}, 32'h1);
        op_ready = 1'b1;
        repeat (4) tick();

        start_sample(32'h3F800000);
        drain(-1, 0);
`ifdef IIR_FEEDBACK_EN
        give_y(32'h3F800000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1);
    end

endmodule
